uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets four byte-stream requesters share one UART TX FIFO write port.
// Optional owner-stall timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int MAX_BURST = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [7:0]  fifo_wdata,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]  rr_pick, cand;
  logic        rr_found;
  logic        owner_valid, xfer_go, end_burst;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [5:0] IDLE_LIMIT = 6'd63;
  logic [5:0]  idle_cnt_q, idle_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // Search order starts just after the previous owner; offset 4 wraps back to it.
  always_comb begin
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int off = 1; off <= 4; off++) begin
      cand = last_grant_q + 2'(off);
      if (!rr_found && req_valid[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

  // A byte moves only when the owner's valid and its ready are both high in the same
  // cycle; ready mirrors ~fifo_full for the owner alone and is never gated by valid.
  assign owner_valid = req_valid[grant_q];
  assign xfer_go     = (state_q == XFER) && owner_valid && !fifo_full;
  assign end_burst   = req_last[grant_q] || (burst_cnt_q == 8'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (state_q == XFER) begin
      req_ready[grant_q] = !fifo_full;
    end
  end

  assign fifo_wr_en = xfer_go;
  assign fifo_wdata = xfer_go ? req_data[{grant_q, 3'b000} +: 8] : 8'h00;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (rr_found) begin
          grant_d     = rr_pick;
          burst_cnt_d = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (xfer_go) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (end_burst) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        // A silent owner is evicted once its idle run would reach the limit.
        if (owner_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LIMIT - 6'd1) begin
          idle_cnt_d   = '0;
          state_d      = IDLE;
          last_grant_d = grant_q;
          timeout_d    = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 6'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      burst_cnt_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == XFER);
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-requester byte sources, a packet-level arbitration model
// that predicts the FIFO write stream, and directed scenarios for bursts, stalls and resets.
module tb_uart_tx_arb;
  localparam int MAX_BURST = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  fifo_wdata;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  uart_tx_arb #(.MAX_BURST(MAX_BURST)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wdata(fifo_wdata),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 PCLK = ~PCLK;

  int n_total = 0, n_pass = 0, n_fail = 0;
  logic [8:0] src_mem [4][256];
  int rd_p [4];
  int wr_p [4];
  logic [9:0] exp_q [$];
  logic [1:0] exp_g_q [$];
  logic [1:0] grant_log [$];
  int wr_cyc [$];
  int cyc = 0, test_writes = 0, m_last = 3;
  int stall_left = 0, stall_at = -1, stall_seen = 0;
  int hold_left = 0, hold_at = -1, hold_id = 0;
  int start_cyc;
  bit rand_full = 0, prev_busy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] glog(input int i);
    return (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] wgap(input int i);
    return (i < wr_cyc.size() && i > 0) ? 32'(wr_cyc[i] - wr_cyc[i-1]) : 32'hdead;
  endfunction

  task automatic load_pkt(input int id, input int len);
    logic lst;
    for (int b = 0; b < len; b++) begin
      lst = (b == len - 1);
      src_mem[id][wr_p[id]] = {lst, 8'($urandom_range(0, 255))};
      wr_p[id]++;
    end
  endtask

  // Packet-level model: owner = first requester after the previous owner that has bytes
  // queued; it sends until its last byte or MAX_BURST bytes, whichever comes first.
  task automatic plan();
    int p [4];
    int c, k, n;
    logic [8:0] e;
    bit done;
    for (int i = 0; i < 4; i++) p[i] = rd_p[i];
    for (int g = 0; g < 1000; g++) begin
      c = -1;
      for (int off = 1; off <= 4; off++) begin
        k = (m_last + off) % 4;
        if (c < 0 && p[k] < wr_p[k]) c = k;
      end
      if (c < 0) break;
      n = 0;
      done = 0;
      while (!done) begin
        e = src_mem[c][p[c]];
        p[c]++;
        n++;
        exp_q.push_back({2'(c), e[7:0]});
        done = e[8] || (n == MAX_BURST) || (p[c] == wr_p[c]);
      end
      exp_g_q.push_back(2'(c));
      m_last = c;
    end
  endtask

  task automatic cycle();
    logic [1:0] eid;
    logic [3:0] exp_rdy;
    logic       exp_wr, exp_to;
    bit         have_exp, hold_act, stalled, v;
    int         k;
    hold_act = (hold_left > 0);
    k = 71 - hold_left;
    for (int i = 0; i < 4; i++) begin
      v = (rd_p[i] < wr_p[i]) && !(hold_act && hold_id == i);
      req_valid[i] = v;
      req_data[8*i +: 8] = v ? src_mem[i][rd_p[i]][7:0] : 8'($urandom_range(0, 255));
      req_last[i] = v ? src_mem[i][rd_p[i]][8] : 1'($urandom_range(0, 1));
    end
    stalled = (stall_left > 0);
    if (stalled) begin
      fifo_full = 1'b1;
      stall_left--;
    end else begin
      fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    @(negedge PCLK);
    have_exp = (exp_q.size() > 0);
    eid = have_exp ? exp_q[0][9:8] : 2'd0;
    if (busy && !prev_busy) grant_log.push_back(grant_id);
    if (busy && have_exp) chk("grant_id", grant_id, eid);
    exp_rdy = (busy && have_exp && !fifo_full) ? 4'(1 << eid) : 4'b0000;
    if (!busy || have_exp) chk("req_ready", req_ready, exp_rdy);
    exp_wr = busy && have_exp && req_valid[eid] && !fifo_full;
    chk("fifo_wr_en", fifo_wr_en, exp_wr);
`ifdef UART_ARB_TIMEOUT_EN
    exp_to = hold_act && (k == 64);
    if (hold_act) chk("busy_owner_silent", busy, (k <= 63));
`else
    exp_to = 1'b0;
    if (hold_act) chk("busy_owner_silent", busy, 1'b1);
`endif
    chk("timeout_err", timeout_err, exp_to);
    if (stalled && !fifo_wr_en && req_ready == 4'b0000) stall_seen++;
    if (hold_act) hold_left--;
    if (fifo_wr_en && exp_wr) begin
      chk("fifo_wdata", fifo_wdata, exp_q[0][7:0]);
      void'(exp_q.pop_front());
      rd_p[eid]++;
      test_writes++;
      wr_cyc.push_back(cyc);
      if (test_writes == stall_at) stall_left = 5;
      if (test_writes == hold_at) hold_left = 70;
    end
    prev_busy = busy;
    cyc++;
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset(input string tag);
    PRESET = 1'b1;
    #1;
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " grant_id"}, grant_id, 2'd0);
    chk({tag, " req_ready"}, req_ready, 4'b0000);
    chk({tag, " fifo_wr_en"}, fifo_wr_en, 1'b0);
    chk({tag, " fifo_wdata"}, fifo_wdata, 8'h00);
    chk({tag, " timeout_err"}, timeout_err, 1'b0);
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_p[i] = 0;
      wr_p[i] = 0;
    end
    exp_q.delete();
    exp_g_q.delete();
    grant_log.delete();
    wr_cyc.delete();
    m_last = 3;
    prev_busy = 0;
    test_writes = 0;
    stall_at = -1;
    stall_left = 0;
    hold_at = -1;
    hold_left = 0;
    rand_full = 0;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  task automatic finish_test(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, " drained"}, exp_q.size(), 0);
    repeat (3) cycle();
    chk({tag, " idle at end"}, busy, 1'b0);
  endtask

  task automatic check_grants(input string tag);
    chk({tag, " grant count"}, grant_log.size(), exp_g_q.size());
    for (int i = 0; i < exp_g_q.size() && i < grant_log.size(); i++)
      chk({tag, " grant order"}, grant_log[i], exp_g_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    do_reset("reset");

    // Requesters 1 and 2 pending after reset: 1 wins first, then 2.
    load_pkt(1, 3);
    load_pkt(2, 2);
    plan();
    start_cyc = cyc;
    finish_test("pair", 100);
    check_grants("pair");
    chk("pair first grant", glog(0), 1);
    chk("pair second grant", glog(1), 2);
    // Valid seen in the IDLE cycle; the write strobe is up the next cycle (lands on edge 2).
    chk("pair first write latency", (wr_cyc.size() > 0) ? 32'(wr_cyc[0] - start_cyc) : 32'hdead, 1);

    // All four busy, one-byte packets: strict rotation, one write every two cycles.
    do_reset("reset2");
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) load_pkt(i, 1);
    plan();
    finish_test("rotate", 100);
    check_grants("rotate");
    for (int i = 0; i < 5; i++) chk("rotate order", glog(i), i % 4);
    for (int i = 1; i < 8; i++) chk("rotate spacing", wgap(i), 2);

    // 20-byte packet from 0 is cut at MAX_BURST; pending requester 3 goes next.
    do_reset("reset3");
    load_pkt(0, 20);
    load_pkt(3, 2);
    plan();
    finish_test("burst", 200);
    check_grants("burst");
    chk("burst order 0", glog(0), 0);
    chk("burst order 1", glog(1), 3);
    chk("burst order 2", glog(2), 0);
    chk("burst 16 back-to-back", (wr_cyc.size() > 15) ? 32'(wr_cyc[15] - wr_cyc[0]) : 32'hdead, 15);
    chk("burst release bubble", wgap(16), 2);

    // FIFO full for 5 cycles mid-packet.
    do_reset("reset4");
    load_pkt(1, 8);
    plan();
    stall_at = 3;
    stall_seen = 0;
    finish_test("stall", 100);
    chk("stall cycles blocked", stall_seen, 5);
    chk("stall byte count", test_writes, 8);

    // Randomised packets with random FIFO back-pressure.
    do_reset("reset5");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) load_pkt(i, $urandom_range(1, 24));
    plan();
    rand_full = 1;
    finish_test("random", 3000);
    check_grants("random");
    rand_full = 0;

    // Owner goes silent for 70 cycles mid-packet.
    do_reset("reset6");
    load_pkt(2, 10);
    plan();
    hold_id = 2;
    hold_at = 4;
    finish_test("silent", 400);
    chk("silent byte count", test_writes, 10);
`ifdef UART_ARB_TIMEOUT_EN
    chk("silent grant count", grant_log.size(), 2);
`else
    chk("silent grant count", grant_log.size(), 1);
`endif

    // Reset in the middle of a packet aborts it; requester 0 wins next.
    do_reset("reset7");
    load_pkt(1, 6);
    plan();
    for (int n = 0; n < 20 && test_writes < 2; n++) cycle();
    chk("abort busy before reset", busy, 1'b1);
    do_reset("abort");
    load_pkt(3, 2);
    load_pkt(0, 2);
    plan();
    finish_test("after abort", 100);
    check_grants("after abort");
    chk("after abort first grant", glog(0), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
